// File: rtl/dff_link_pkg.sv
// Shared constants for the DFF error-count serial link: frame geometry, word order
// and receiver state encodings, common to the on-chip serializer and this receiver.
package dff_link_pkg;

    localparam int WORD_W          = 12;
    localparam int NUM_WORDS       = 20;
    localparam int IDX_W           = 5;
    localparam int NUM_CHIPS       = 2;
    localparam int CHAINS_PER_CHIP = 10;
    localparam int FRAME_BITS      = WORD_W * NUM_WORDS;
    localparam int BIT_CNT_W       = $clog2(WORD_W);

    localparam logic [IDX_W-1:0]     LAST_WORD_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]     NUM_WORDS_IDX = IDX_W'(NUM_WORDS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT      = BIT_CNT_W'(WORD_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // Frame order: chip0 chain0..9, then chip1 chain0..9.
    function automatic logic [IDX_W-1:0] frame_slot(input int chip, input int chain);
        return IDX_W'(chip * CHAINS_PER_CHIP + chain);
    endfunction

endpackage

// File: rtl/dff_rx_bank.sv
// Shadow bank filled word by word during a frame, plus a read bank that takes the
// whole frame at once on commit; registered read port with out-of-range reads returning 0.
module dff_rx_bank
    import dff_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              commit,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] shadow_q [NUM_WORDS];
    logic [WORD_W-1:0] shadow_d [NUM_WORDS];
    logic [WORD_W-1:0] bank_q   [NUM_WORDS];
    logic [WORD_W-1:0] bank_d   [NUM_WORDS];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // Commit copies the post-write shadow so the word landing on the commit edge is included.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            shadow_d[i] = shadow_q[i];
            bank_d[i]   = bank_q[i];
            if (wr_en && (wr_addr == IDX_W'(i))) begin
                shadow_d[i] = wr_data;
            end
            if (commit) begin
                bank_d[i] = shadow_d[i];
            end
        end
        rd_data_d = '0;
        if (rd_addr < NUM_WORDS_IDX) begin
            rd_data_d = bank_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= '0;
                bank_q[i]   <= '0;
            end
            rd_data_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            bank_q    <= bank_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dff_data_receiver.sv
// Receiving end of the DFF error-count link: deserializes LSB-first 12-bit counts,
// publishes each word, and commits complete frames into a host-readable bank.
module dff_data_receiver
    import dff_link_pkg::*;
(
    input  logic              data_clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              rx_en,
    input  logic              clear_err,
    output logic [WORD_W-1:0] word_data,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_valid,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              frame_err,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    rx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]    sr_q, sr_d;
    logic [WORD_W-1:0]    word_data_q, word_data_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic                 word_valid_q, word_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic [WORD_W-1:0]    shift_word;
    logic                 wr_en;
    logic                 commit;

    // New bit enters at the MSB, so after WORD_W shifts the first bit sits at bit 0.
    assign shift_word = {data_in, sr_q[WORD_W-1:1]};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        sr_d         = sr_q;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        word_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        frame_err_d  = clear_err ? 1'b0 : frame_err_q;
        wr_en        = 1'b0;
        commit       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_en) begin
                    sr_d       = shift_word;
                    bit_cnt_d  = BIT_CNT_W'(1);
                    word_cnt_d = '0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    // Dropping rx_en exactly on a frame boundary is a clean stop, not an error.
                    if ((bit_cnt_q != '0) || (word_cnt_q != '0)) begin
                        frame_err_d = 1'b1;
                    end
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    sr_d = shift_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        word_data_d  = shift_word;
                        word_idx_d   = word_cnt_q;
                        word_valid_d = 1'b1;
                        wr_en        = 1'b1;
                        bit_cnt_d    = '0;
                        if (word_cnt_q == LAST_WORD_IDX) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            commit       = 1'b1;
                            word_cnt_d   = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sr_q         <= '0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sr_q         <= sr_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_err_q  <= frame_err_d;
        end
    end

    dff_rx_bank u_bank (
        .clk     (data_clk),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_addr (word_cnt_q),
        .wr_data (shift_word),
        .commit  (commit),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign word_data  = word_data_q;
    assign word_idx   = word_idx_q;
    assign word_valid = word_valid_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_err  = frame_err_q;

endmodule
